// File: rtl/riscv_defs_pkg.sv
// RV32I encodings shared by the execution units: opcodes, ALU/branch funct3 codes,
// and default datapath widths.
package riscv_defs;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned ROB_W_DEF = 4;

  typedef enum logic [6:0] {
    OPC_OP     = 7'b0110011,
    OPC_OP_IMM = 7'b0010011,
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_BRANCH = 7'b1100011
  } opcode_e;

  typedef enum logic [2:0] {
    F3_ADD  = 3'b000,
    F3_SLL  = 3'b001,
    F3_SLT  = 3'b010,
    F3_SLTU = 3'b011,
    F3_XOR  = 3'b100,
    F3_SR   = 3'b101,
    F3_OR   = 3'b110,
    F3_AND  = 3'b111
  } alu_f3_e;

  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } br_f3_e;

endpackage

// File: rtl/alu_unit_core.sv
// Purely combinational RV32I integer/branch evaluation: produces the writeback value,
// the taken flag and the next PC for one issued op.
module alu_core
  import riscv_defs::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  logic [6:0]      i_opcode,
  input  logic [2:0]      i_precise,
  input  logic            i_more_precise,
  input  logic [XLEN-1:0] i_value_1,
  input  logic [XLEN-1:0] i_value_2,
  input  logic [XLEN-1:0] i_value_pc,
  input  logic [XLEN-1:0] i_imm,
  output logic [XLEN-1:0] o_value,
  output logic            o_jump,
  output logic [XLEN-1:0] o_target
);

  logic [XLEN-1:0] w_b;
  logic [4:0]      w_shamt;
  logic [XLEN-1:0] w_alu;
  logic [XLEN-1:0] w_pc4;
  logic [XLEN-1:0] w_pc_imm;
  logic [XLEN-1:0] w_jalr;
  logic            w_cond;

  assign w_b      = (i_opcode == OPC_OP) ? i_value_2 : i_imm;
  assign w_shamt  = w_b[4:0];
  assign w_pc4    = i_value_pc + XLEN'(4);
  assign w_pc_imm = i_value_pc + i_imm;
  assign w_jalr   = (i_value_1 + i_imm) & ~XLEN'(1);

  // instr[30] only selects SUB for register-register ops; for ADDI it is an immediate bit
  always_comb begin
    w_alu = '0;
    case (i_precise)
      F3_ADD:  w_alu = (i_opcode == OPC_OP && i_more_precise) ? i_value_1 - w_b
                                                               : i_value_1 + w_b;
      F3_SLL:  w_alu = i_value_1 << w_shamt;
      F3_SLT:  w_alu = XLEN'($signed(i_value_1) < $signed(w_b));
      F3_SLTU: w_alu = XLEN'(i_value_1 < w_b);
      F3_XOR:  w_alu = i_value_1 ^ w_b;
      F3_SR:   w_alu = i_more_precise ? XLEN'($signed(i_value_1) >>> w_shamt)
                                      : i_value_1 >> w_shamt;
      F3_OR:   w_alu = i_value_1 | w_b;
      F3_AND:  w_alu = i_value_1 & w_b;
      default: w_alu = '0;
    endcase
  end

  always_comb begin
    w_cond = 1'b0;
    case (i_precise)
      F3_BEQ:  w_cond = (i_value_1 == i_value_2);
      F3_BNE:  w_cond = (i_value_1 != i_value_2);
      F3_BLT:  w_cond = ($signed(i_value_1) < $signed(i_value_2));
      F3_BGE:  w_cond = ($signed(i_value_1) >= $signed(i_value_2));
      F3_BLTU: w_cond = (i_value_1 < i_value_2);
      F3_BGEU: w_cond = (i_value_1 >= i_value_2);
      default: w_cond = 1'b0;
    endcase
  end

  always_comb begin
    o_value  = '0;
    o_jump   = 1'b0;
    o_target = w_pc4;
    case (i_opcode)
      OPC_OP, OPC_OP_IMM: o_value = w_alu;
      OPC_LUI:            o_value = i_imm;
      OPC_AUIPC:          o_value = w_pc_imm;
      OPC_JAL: begin
        o_value  = w_pc4;
        o_jump   = 1'b1;
        o_target = w_pc_imm;
      end
      OPC_JALR: begin
        o_value  = w_pc4;
        o_jump   = 1'b1;
        o_target = w_jalr;
      end
      OPC_BRANCH: begin
        o_jump   = w_cond;
        o_target = w_cond ? w_pc_imm : w_pc4;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_unit.sv
// Integer execution unit: accepts one issued op per cycle, evaluates it, and queues the
// result in a small FIFO whose head is broadcast on the CDB under a grant handshake.
module alu_unit
  import riscv_defs::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned ROB_W = ROB_W_DEF,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rdy,
  input  logic             rollback,
  input  logic             in_config,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_value_1,
  input  logic [XLEN-1:0]  in_value_2,
  input  logic [XLEN-1:0]  in_value_pc,
  input  logic [6:0]       in_opcode,
  input  logic [2:0]       in_precise,
  input  logic             in_more_precise,
  input  logic [XLEN-1:0]  in_imm,
  input  logic [ROB_W-1:0] in_rob_entry,
  output logic             cdb_valid,
  input  logic             cdb_grant,
  output logic [ROB_W-1:0] cdb_rob_entry,
  output logic [XLEN-1:0]  cdb_value,
  output logic             cdb_jump,
  output logic [XLEN-1:0]  cdb_target_pc
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [XLEN-1:0]  w_value;
  logic             w_jump;
  logic [XLEN-1:0]  w_target;
  logic             w_push;
  logic             w_pop;

  logic [CNT_W-1:0] r_count;
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [ROB_W-1:0] r_rob    [DEPTH];
  logic [XLEN-1:0]  r_value  [DEPTH];
  logic             r_jump   [DEPTH];
  logic [XLEN-1:0]  r_target [DEPTH];

  alu_core #(.XLEN(XLEN)) u_core (
    .i_opcode       (in_opcode),
    .i_precise      (in_precise),
    .i_more_precise (in_more_precise),
    .i_value_1      (in_value_1),
    .i_value_2      (in_value_2),
    .i_value_pc     (in_value_pc),
    .i_imm          (in_imm),
    .o_value        (w_value),
    .o_jump         (w_jump),
    .o_target       (w_target)
  );

  assign in_ready  = (r_count != CNT_W'(DEPTH));
  assign cdb_valid = (r_count != '0);
  assign w_push    = rdy & in_config & in_ready & ~rollback;
  assign w_pop     = rdy & cdb_valid & cdb_grant & ~rollback;

  assign cdb_rob_entry = r_rob[r_head];
  assign cdb_value     = r_value[r_head];
  assign cdb_jump      = r_jump[r_head];
  assign cdb_target_pc = r_target[r_head];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_rob[i]    <= '0;
        r_value[i]  <= '0;
        r_jump[i]   <= 1'b0;
        r_target[i] <= '0;
      end
    end else if (rdy) begin
      if (rollback) begin
        r_count <= '0;
        r_head  <= '0;
        r_tail  <= '0;
      end else begin
        if (w_push) begin
          r_rob[r_tail]    <= in_rob_entry;
          r_value[r_tail]  <= w_value;
          r_jump[r_tail]   <= w_jump;
          r_target[r_tail] <= w_target;
          r_tail           <= r_tail + PTR_W'(1);
        end
        if (w_pop) r_head <= r_head + PTR_W'(1);
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CNT_W'(1);
          2'b01:   r_count <= r_count - CNT_W'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

endmodule
